wb_result_buffer: RTL and testbench

- Unit-side producer for the writeback interface; the counterpart of the writeback arbiter that selects completed units and acks them.
- Sits at the output of an execution unit with variable completion latency (div, load, CSR).
- Queues completed results (id, rd data) in a small in-order FIFO and presents the oldest entry as done/id/rd.
- Holds the entry until the arbiter acks it; back-pressures the unit when full.

---
 rtl/wb_result_buffer.sv | 111 +++++++++++
 tb/tb_wb_result_buffer.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/wb_result_buffer.sv
// In-order result queue between a variable-latency unit and writeback; WB_RESULT_BUFFER_BYPASS_EN adds same-cycle offer.
// Latency: 1 cycle push-to-wb_done (0 with bypass when empty); ack pops the head entry.
// Backpressure: result_ready drops at DEPTH entries; a result pushed while not ready is dropped and flags overflow_err.
module wb_result_buffer #(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 3
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_flush,
  input  logic                     i_result_valid,
  input  logic [ID_WIDTH-1:0]      i_result_id,
  input  logic [DATA_WIDTH-1:0]    i_result_data,
  output logic                     o_result_ready,
  output logic                     o_wb_done,
  output logic [ID_WIDTH-1:0]      o_wb_id,
  output logic [DATA_WIDTH-1:0]    o_wb_rd,
  input  logic                     i_wb_ack,
  output logic [$clog2(DEPTH):0]   o_occupancy,
  output logic                     o_overflow_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [ID_WIDTH-1:0]   id;
    logic [DATA_WIDTH-1:0] rd;
  } entry_t;

  entry_t          r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            r_overflow;

  entry_t          w_head;
  entry_t          w_in;
  logic            w_ready;
  logic            w_not_empty;
  logic            w_push;
  logic            w_pop;

  assign w_head      = r_mem[r_rd_ptr];
  assign w_in        = '{id: i_result_id, rd: i_result_data};
  assign w_ready     = (r_count != FULL);
  assign w_not_empty = (r_count != '0);
  assign w_pop       = i_wb_ack & w_not_empty & ~i_flush;

`ifdef WB_RESULT_BUFFER_BYPASS_EN
  logic w_bypass;

  // An empty buffer forwards the incoming result; it only lands in storage if not acked now.
  assign w_bypass  = ~w_not_empty & i_result_valid;
  assign w_push    = i_result_valid & w_ready & ~i_flush & ~(w_bypass & i_wb_ack);
  assign o_wb_done = w_not_empty | w_bypass;
  assign o_wb_id   = w_bypass ? i_result_id   : w_head.id;
  assign o_wb_rd   = w_bypass ? i_result_data : w_head.rd;
`else
  assign w_push    = i_result_valid & w_ready & ~i_flush;
  assign o_wb_done = w_not_empty;
  assign o_wb_id   = w_head.id;
  assign o_wb_rd   = w_head.rd;
`endif

  assign o_result_ready = w_ready;
  assign o_occupancy    = r_count;
  assign o_overflow_err = r_overflow;

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_in;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky until reset; flush deliberately leaves it alone.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_overflow <= 1'b0;
    end else if (i_result_valid & ~w_ready) begin
      r_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_result_buffer.sv
// Directed bench for wb_result_buffer: vector table plus hand sequences for reset, async reset and bypass.
module tb_wb_result_buffer;

  localparam int DEPTH = 4;
  localparam int DW    = 32;
  localparam int IW    = 4;

  logic            clk;
  logic            rst;
  logic            flush;
  logic            result_valid;
  logic [IW-1:0]   result_id;
  logic [DW-1:0]   result_data;
  logic            result_ready;
  logic            wb_done;
  logic [IW-1:0]   wb_id;
  logic [DW-1:0]   wb_rd;
  logic            wb_ack;
  logic [2:0]      occupancy;
  logic            overflow_err;

  wb_result_buffer #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_flush        (flush),
    .i_result_valid (result_valid),
    .i_result_id    (result_id),
    .i_result_data  (result_data),
    .o_result_ready (result_ready),
    .o_wb_done      (wb_done),
    .o_wb_id        (wb_id),
    .o_wb_rd        (wb_rd),
    .i_wb_ack       (wb_ack),
    .o_occupancy    (occupancy),
    .o_overflow_err (overflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          f;
    logic          v;
    logic [IW-1:0] id;
    logic [DW-1:0] d;
    logic          a;
    logic          e_done;
    logic [IW-1:0] e_id;
    logic [DW-1:0] e_rd;
    logic          e_rdy;
    logic [2:0]    e_occ;
    logic          e_ovf;
  } vec_t;

  vec_t vecs [64];
  int   nvec  = 0;
  int   tests = 0;
  int   fails = 0;

  task automatic add(input logic f, input logic v, input int id, input logic [DW-1:0] d,
                     input logic a, input logic ed, input int eid, input logic [DW-1:0] erd,
                     input logic er, input int eo, input logic ev);
    vecs[nvec] = '{f: f, v: v, id: IW'(id), d: d, a: a, e_done: ed, e_id: IW'(eid),
                   e_rd: erd, e_rdy: er, e_occ: 3'(eo), e_ovf: ev};
    nvec++;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle();
    flush = 1'b0; result_valid = 1'b0; wb_ack = 1'b0;
    result_id = '0; result_data = '0;
  endtask

  task automatic check_state(input string nm, input logic ed, input logic [IW-1:0] eid,
                             input logic [DW-1:0] erd, input logic er, input logic [2:0] eo,
                             input logic ev);
    chk({nm, ".done"}, 64'(wb_done), 64'(ed));
    chk({nm, ".ready"}, 64'(result_ready), 64'(er));
    chk({nm, ".occ"}, 64'(occupancy), 64'(eo));
    chk({nm, ".ovf"}, 64'(overflow_err), 64'(ev));
    if (ed) begin
      chk({nm, ".id"}, 64'(wb_id), 64'(eid));
      chk({nm, ".rd"}, 64'(wb_rd), 64'(erd));
    end
  endtask

  initial begin
    rst = 1'b0;
    idle();

    // Single result, then a spurious ack on the empty buffer
    add(0,1,2,32'hDEADBEEF,0, 1,2,32'hDEADBEEF,1,1,0);
    add(0,0,0,0,0,            1,2,32'hDEADBEEF,1,1,0);
    add(0,0,0,0,0,            1,2,32'hDEADBEEF,1,1,0);
    add(0,0,0,0,1,            0,0,0,1,0,0);
    add(0,0,0,0,1,            0,0,0,1,0,0);
    // Wrap: ten results, ack every cycle after the first
    add(0,1,0,32'hA0,0,       1,0,32'hA0,1,1,0);
    for (int k = 1; k < 10; k++)
      add(0,1,k,32'hA0 + 32'(k),1, 1,k,32'hA0 + 32'(k),1,1,0);
    add(0,0,0,0,1,            0,0,0,1,0,0);
    // Fill to DEPTH, then ack alone and push+ack at full-minus-one
    for (int k = 0; k < 4; k++)
      add(0,1,k,32'h100 + 32'(k),0, 1,0,32'h100,(k != 3),k+1,0);
    add(0,0,0,0,1,            1,1,32'h101,1,3,0);
    add(0,1,5,32'h105,1,      1,2,32'h102,1,3,0);
    add(0,0,0,0,1,            1,3,32'h103,1,2,0);
    add(0,0,0,0,1,            1,5,32'h105,1,1,0);
    add(0,0,0,0,1,            0,0,0,1,0,0);
    // Overflow: push while full is dropped, drain shows 0..3 only
    for (int k = 0; k < 4; k++)
      add(0,1,k,32'h100 + 32'(k),0, 1,0,32'h100,(k != 3),k+1,0);
    add(0,1,4,32'h104,0,      1,0,32'h100,0,4,1);
    add(0,0,0,0,1,            1,1,32'h101,1,3,1);
    add(0,0,0,0,1,            1,2,32'h102,1,2,1);
    add(0,0,0,0,1,            1,3,32'h103,1,1,1);
    add(0,0,0,0,1,            0,0,0,1,0,1);
    // Flush beats a same-cycle push and ack; overflow_err survives
    for (int k = 1; k < 4; k++)
      add(0,1,k,32'h200 + 32'(k),0, 1,1,32'h201,1,k,1);
    add(1,1,6,32'h206,1,      0,0,0,1,0,1);
    add(0,1,4,32'h204,0,      1,4,32'h204,1,1,1);
    add(0,1,5,32'h205,0,      1,4,32'h204,1,2,1);

    #2;
    check_state("reset", 0, 0, 0, 1, 0, 0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < nvec; i++) begin
      @(negedge clk);
      flush = vecs[i].f; result_valid = vecs[i].v; result_id = vecs[i].id;
      result_data = vecs[i].d; wb_ack = vecs[i].a;
      @(posedge clk);
      #1 idle();
      #1 check_state($sformatf("v%0d", i), vecs[i].e_done, vecs[i].e_id, vecs[i].e_rd,
                     vecs[i].e_rdy, vecs[i].e_occ, vecs[i].e_ovf);
    end

    // Async reset mid-cycle with two entries queued
    @(negedge clk);
    #1 rst = 1'b0;
    #1 check_state("arst", 0, 0, 0, 1, 0, 0);
    @(negedge clk);
    rst = 1'b1;

    @(negedge clk);
    result_valid = 1'b1; result_id = 4'd6; result_data = 32'h606; wb_ack = 1'b1;
    #1;
`ifdef WB_RESULT_BUFFER_BYPASS_EN
    check_state("byp.same", 1, 6, 32'h606, 1, 0, 0);
    @(posedge clk);
    #1 idle();
    #1 check_state("byp.next", 0, 0, 0, 1, 0, 0);
`else
    check_state("nobyp.same", 0, 0, 0, 1, 0, 0);
    @(posedge clk);
    #1 idle();
    #1 check_state("nobyp.next", 1, 6, 32'h606, 1, 1, 0);
    @(negedge clk);
    wb_ack = 1'b1;
    @(posedge clk);
    #1 idle();
    #1 check_state("nobyp.drain", 0, 0, 0, 1, 0, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
